// File: rtl/jk_bank_if.sv
// Control/data bundle for the JK flip-flop bank: mode, per-bit inputs and state outputs.
interface jk_bank_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_b;
  logic             tc;
  logic             chg;

  modport master (
    output en, mode, j, k, d,
    input  q, q_b, tc, chg
  );

  modport slave (
    input  en, mode, j, k, d,
    output q, q_b, tc, chg
  );
endinterface

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops with JK/T/D-load/COUNT modes; q and chg one edge after sampling.
// No backpressure: en=0 holds state, q_b and tc are combinational from q.
module jk_bank #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic      i_clk,
  input  logic      i_rst,
  jk_bank_if.slave  bus
);
  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_T     = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             r_chg;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH:0]   w_carry;

  // Ripple carry: bit i toggles only when every lower bit is already 1.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_carry[i+1] = w_carry[i] & r_q[i];
    end
  end

  always_comb begin
    w_next = r_q;
    if (bus.en) begin
      unique case (bus.mode)
        MODE_JK:    w_next = (bus.j & ~r_q) | (~bus.k & r_q);
        MODE_T:     w_next = r_q ^ bus.j;
        MODE_LOAD:  w_next = bus.d;
        MODE_COUNT: w_next = r_q ^ w_carry[WIDTH-1:0];
        default:    w_next = r_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q   <= RST_VAL;
      r_chg <= 1'b0;
    end else begin
      r_q   <= w_next;
      r_chg <= (w_next != r_q);
    end
  end

  assign bus.q   = r_q;
  assign bus.q_b = ~r_q;
  assign bus.tc  = (bus.mode == MODE_COUNT) && (&r_q);
  assign bus.chg = r_chg;
endmodule

// File: tb/tb_jk_bank.sv
// Directed-vector bench for jk_bank (WIDTH=4, RST_VAL=0) with hand-computed expectations.
module tb_jk_bank;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  jk_bank_if #(.WIDTH(4)) bus ();

  jk_bank #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge, outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.mode = 2'b11;
    bus.j = 4'b1011; bus.k = 4'b0110; bus.d = 4'b1111;
    tick();
    n_vec++;
    if (bus.q !== 4'b0000 || bus.chg !== 1'b0 || bus.q_b !== 4'b1111 || bus.tc !== 1'b0) begin
      n_err++;
      $display("FAIL reset: q=%b chg=%b q_b=%b tc=%b, want q=0000 chg=0 q_b=1111 tc=0",
               bus.q, bus.chg, bus.q_b, bus.tc);
    end
    rst = 1'b0;
  endtask

  task automatic test_jk_truth();
    logic [3:0] jv [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b1111};
    logic [3:0] kv [4] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
    logic [3:0] qv [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};
    logic       cv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    bus.mode = 2'b00; bus.en = 1'b1; bus.d = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      bus.j = jv[i]; bus.k = kv[i];
      tick();
      n_vec++;
      if (bus.q !== qv[i] || bus.chg !== cv[i]) begin
        n_err++;
        $display("FAIL jk_truth[%0d]: q=%b chg=%b, want q=%b chg=%b", i, bus.q, bus.chg, qv[i], cv[i]);
      end
    end
  endtask

  task automatic test_jk_mix();
    logic [3:0] jv [3] = '{4'b1010, 4'b0001, 4'b1111};
    logic [3:0] kv [3] = '{4'b0000, 4'b1000, 4'b1111};
    logic [3:0] qv [3] = '{4'b1010, 4'b0011, 4'b1100};
    apply_reset();
    bus.mode = 2'b00; bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.j = jv[i]; bus.k = kv[i];
      tick();
      n_vec++;
      if (bus.q !== qv[i] || bus.q_b !== ~qv[i] || bus.chg !== 1'b1) begin
        n_err++;
        $display("FAIL jk_mix[%0d]: q=%b q_b=%b chg=%b, want q=%b q_b=%b chg=1",
                 i, bus.q, bus.q_b, bus.chg, qv[i], ~qv[i]);
      end
    end
  endtask

  task automatic test_t_enable();
    logic [3:0] qv [3] = '{4'b0101, 4'b0000, 4'b0101};
    apply_reset();
    bus.mode = 2'b01; bus.en = 1'b1; bus.j = 4'b0101; bus.k = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (bus.q !== qv[i] || bus.chg !== 1'b1) begin
        n_err++;
        $display("FAIL t_mode[%0d]: q=%b chg=%b, want q=%b chg=1", i, bus.q, bus.chg, qv[i]);
      end
    end
    bus.en = 1'b0;
    tick();
    n_vec++;
    if (bus.q !== 4'b0101 || bus.chg !== 1'b0) begin
      n_err++;
      $display("FAIL t_hold: q=%b chg=%b, want q=0101 chg=0", bus.q, bus.chg);
    end
    bus.en = 1'b1; bus.j = 4'b0000;
    tick();
    n_vec++;
    if (bus.q !== 4'b0101 || bus.chg !== 1'b0) begin
      n_err++;
      $display("FAIL t_zero: q=%b chg=%b, want q=0101 chg=0", bus.q, bus.chg);
    end
  endtask

  task automatic test_en_hold_all_modes();
    apply_reset();
    bus.mode = 2'b10; bus.en = 1'b1; bus.d = 4'b0110;
    tick();
    bus.en = 1'b0; bus.j = 4'b1111; bus.k = 4'b1111; bus.d = 4'b1001;
    for (int m = 0; m < 4; m++) begin
      bus.mode = 2'(m);
      tick();
      n_vec++;
      if (bus.q !== 4'b0110 || bus.chg !== 1'b0) begin
        n_err++;
        $display("FAIL en_hold[mode=%0d]: q=%b chg=%b, want q=0110 chg=0", m, bus.q, bus.chg);
      end
    end
  endtask

  task automatic test_count_wrap();
    logic [3:0] qv [4] = '{4'b1110, 4'b1111, 4'b0000, 4'b0001};
    logic       tv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    bus.mode = 2'b10; bus.en = 1'b1; bus.d = 4'b1101;
    tick();
    n_vec++;
    if (bus.q !== 4'b1101 || bus.tc !== 1'b0) begin
      n_err++;
      $display("FAIL load: q=%b tc=%b, want q=1101 tc=0", bus.q, bus.tc);
    end
    bus.mode = 2'b11; bus.j = 4'b1010; bus.k = 4'b0101; bus.d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (bus.q !== qv[i] || bus.tc !== tv[i] || bus.chg !== 1'b1) begin
        n_err++;
        $display("FAIL count[%0d]: q=%b tc=%b chg=%b, want q=%b tc=%b chg=1",
                 i, bus.q, bus.tc, bus.chg, qv[i], tv[i]);
      end
    end
    // All ones outside COUNT mode must not raise tc.
    bus.mode = 2'b10; bus.d = 4'b1111;
    tick();
    n_vec++;
    if (bus.q !== 4'b1111 || bus.tc !== 1'b0) begin
      n_err++;
      $display("FAIL tc_mode: q=%b tc=%b, want q=1111 tc=0", bus.q, bus.tc);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.mode = 2'b10; bus.en = 1'b1; bus.d = 4'b0101;
    tick();
    bus.mode = 2'b11;
    tick();
    n_vec++;
    if (bus.q !== 4'b0110) begin
      n_err++;
      $display("FAIL mid_count: q=%b, want 0110", bus.q);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (bus.q !== 4'b0000 || bus.chg !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: q=%b chg=%b, want q=0000 chg=0", bus.q, bus.chg);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (bus.q !== 4'b0001 || bus.chg !== 1'b1) begin
      n_err++;
      $display("FAIL mid_resume: q=%b chg=%b, want q=0001 chg=1", bus.q, bus.chg);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; bus.mode = 2'b10; bus.d = 4'b1111; bus.en = 1'b1;
    tick();
    n_vec++;
    if (bus.q !== 4'b0000 || bus.chg !== 1'b0) begin
      n_err++;
      $display("FAIL rst_prio: q=%b chg=%b, want q=0000 chg=0", bus.q, bus.chg);
    end
    rst = 1'b0; bus.d = 4'b1001;
    tick();
    n_vec++;
    if (bus.q !== 4'b1001 || bus.chg !== 1'b1) begin
      n_err++;
      $display("FAIL load_new: q=%b chg=%b, want q=1001 chg=1", bus.q, bus.chg);
    end
    tick();
    n_vec++;
    if (bus.q !== 4'b1001 || bus.chg !== 1'b0) begin
      n_err++;
      $display("FAIL load_same: q=%b chg=%b, want q=1001 chg=0", bus.q, bus.chg);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; bus.en = 1'b0; bus.mode = 2'b00;
    bus.j = 4'b0000; bus.k = 4'b0000; bus.d = 4'b0000;
    #2;
    test_reset();
    test_jk_truth();
    test_jk_mix();
    test_t_enable();
    test_en_hold_all_modes();
    test_count_wrap();
    test_reset_mid();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jk_bank.md
JK_BANK -- requirements
Module: jk_bank

Interface
REQ-001 Parameter: WIDTH, default 4, number of JK flip-flop bits in the bank (1..32).
REQ-002 Parameter: RST_VAL, default {WIDTH{1'b0}}, value loaded into q on reset.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset; one clock, synchronous active-high reset.
REQ-005 Port: en  input  1  update enable; when low, q holds in every mode.
REQ-006 Port: mode  input  2  operating mode: 00 JK, 01 T, 10 D-load, 11 COUNT.
REQ-007 Port: j  input  WIDTH  per-bit J (JK mode); also per-bit T in T mode.
REQ-008 Port: k  input  WIDTH  per-bit K (JK mode); ignored in other modes.
REQ-009 Port: d  input  WIDTH  parallel load data (D-load mode).
REQ-010 Port: q  output  WIDTH  registered bank state.
REQ-011 Port: q_b  output  WIDTH  bitwise complement of q, always ~q (combinational).
REQ-012 Port: tc  output  1  terminal count: high when mode==11 and q is all ones (combinational).
REQ-013 Port: chg  output  1  registered flag: high for exactly the cycle after q changed value.

Function
REQ-014 JK mode (00), en=1: per bit i, next q[i] = j0k0 hold, j0k1 clear, j1k0 set, j1k1 toggle.
REQ-015 T mode (01), en=1: per bit i, next q[i] = q[i] XOR j[i]; k is ignored.
REQ-016 D-load mode (10), en=1: next q = d in one cycle; j and k are ignored.
REQ-017 COUNT mode (11), en=1: synchronous up-counter; bit i toggles iff all bits below i are 1 (bit 0 always toggles); j, k and d are ignored.
REQ-018 COUNT wrap-around: from all ones, the next q is all zeros; tc is high while q is all ones and low the cycle after the wrap.
REQ-019 en=0 in any mode: q holds; chg goes low on the next edge.
REQ-020 Mode changes take effect on the edge at which the new mode is sampled; there is no pipeline latency and no history carries across modes.
REQ-021 chg is registered as (next q != q) at each edge with rst low, and is therefore cleared on any hold cycle, including JK 00, T with j=0, and D-load with d==q.
REQ-022 Latency: every input change is visible on q one clock edge after sampling; q_b and tc follow q in the same cycle.
REQ-023 No arithmetic other than the COUNT carry chain exists; counter width is exactly WIDTH, and no bit beyond MSB is stored.

Reset
REQ-024 On a rising edge with rst=1: q=RST_VAL, chg=0, regardless of en, mode, j, k and d.
REQ-025 Reset has priority over all modes; reset mid-count restarts from RST_VAL, and counting resumes on the first edge with rst=0 and en=1.
REQ-026 Before the first reset edge, q is undefined; the bench drives rst=1 for at least one edge first.
REQ-027 After reset, the reset-state outputs are: q_b=~RST_VAL, tc=(mode==11 and RST_VAL all ones), chg=0.

Verification (WIDTH=4, RST_VAL=0)
REQ-028 JK truth table: after reset, mode=00, en=1, apply j/k=0000/0000, 0000/1111, 1111/0000, 1111/1111, with one edge each -> q=0000, 0000, 1111, 0000; chg=0, 0, 1, 1.
REQ-029 Per-bit JK mix: q=0000, then j=1010 k=0000 -> q=1010; then j=0001 k=1000 -> q=0011; then j=1111 k=1111 -> q=1100; q_b=0011.
REQ-030 T mode and enable: q=0000, mode=01, j=0101, 3 edges with en=1 -> q=0101, 0000, 0101; 1 edge with en=0 -> q holds at 0101 and chg=0.
REQ-031 Count wrap: D-load d=1101, then mode=11, en=1, for 4 edges -> q=1110, 1111 (tc=1), 0000 (tc=0), 0001.
REQ-032 Reset mid-operation: counting at q=0110, assert rst with en=1 for one edge -> q=0000, chg=0; release rst -> next edge q=0001, chg=1.
REQ-033 Reset priority: rst=1 with mode=10, d=1111, en=1 -> q=0000; a D-load with d==q -> q unchanged, chg=0.
